// File: rtl/ex_stage_pipe_reg.sv
// ID->EX pipeline stage register with a valid/ready handshake, synchronous flush,
// a saturating flush counter and an optional two-entry skid buffer.
module ex_stage_pipe_reg #(
  parameter int unsigned CTRL_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 144,
  parameter int unsigned SKID       = 1,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            occupancy,
  output logic [CNT_WIDTH-1:0]  flush_count
);

  // State encoding doubles as the entry count.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    HD_HOLD,
    HD_LOAD_IN,
    HD_LOAD_SKID,
    HD_CLEAR
  } head_op_t;

  typedef enum logic [1:0] {
    SK_HOLD,
    SK_LOAD_IN,
    SK_CLEAR
  } skid_op_t;

  state_t                state;
  state_t                state_nxt;
  head_op_t              head_op;
  skid_op_t              skid_op;
  logic                  push;
  logic                  pop;
  logic                  out_valid_q;
  logic [CTRL_WIDTH-1:0] head_ctrl;
  logic [DATA_WIDTH-1:0] head_data;
  logic [CTRL_WIDTH-1:0] skid_ctrl;
  logic [DATA_WIDTH-1:0] skid_data;
  logic [CNT_WIDTH-1:0]  flush_cnt_q;

  assign push = in_valid & in_ready;
  assign pop  = out_valid_q & out_ready;

  // With a skid entry the ready is a flop; without it, ready follows the consumer.
  generate
    if (SKID != 0) begin : g_skid
      logic in_ready_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          in_ready_q <= 1'b1;
        end else begin
          in_ready_q <= (state_nxt != ST_FULL);
        end
      end

      assign in_ready = in_ready_q;
    end else begin : g_no_skid
      assign in_ready = ~out_valid_q | out_ready;
    end
  endgenerate

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (push) state_nxt = ST_ONE;
        end
        ST_ONE: begin
          if (push && !pop) begin
            state_nxt = (SKID != 0) ? ST_FULL : ST_ONE;
          end else if (!push && pop) begin
            state_nxt = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (pop) state_nxt = ST_ONE;
        end
        default: state_nxt = ST_EMPTY;
      endcase
    end
  end

  // Datapath control: invalid entries are cleared so EX sees a NOP bubble
  always_comb begin
    head_op = HD_HOLD;
    skid_op = SK_HOLD;
    if (flush) begin
      head_op = HD_CLEAR;
      skid_op = SK_CLEAR;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (push) head_op = HD_LOAD_IN;
        end
        ST_ONE: begin
          if (push && pop) begin
            head_op = HD_LOAD_IN;
          end else if (push) begin
            skid_op = SK_LOAD_IN;
          end else if (pop) begin
            head_op = HD_CLEAR;
          end
        end
        ST_FULL: begin
          if (pop) begin
            head_op = HD_LOAD_SKID;
            skid_op = SK_CLEAR;
          end
        end
        default: begin
          head_op = HD_CLEAR;
          skid_op = SK_CLEAR;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_ctrl <= '0;
      head_data <= '0;
      skid_ctrl <= '0;
      skid_data <= '0;
    end else begin
      case (head_op)
        HD_LOAD_IN: begin
          head_ctrl <= in_ctrl;
          head_data <= in_data;
        end
        HD_LOAD_SKID: begin
          head_ctrl <= skid_ctrl;
          head_data <= skid_data;
        end
        HD_CLEAR: begin
          head_ctrl <= '0;
          head_data <= '0;
        end
        default: ;
      endcase
      case (skid_op)
        SK_LOAD_IN: begin
          skid_ctrl <= in_ctrl;
          skid_data <= in_data;
        end
        SK_CLEAR: begin
          skid_ctrl <= '0;
          skid_data <= '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= (state_nxt != ST_EMPTY);
    end
  end

  // Count only flushes that actually discard something; hold at all-ones
  always_ff @(posedge clk) begin
    if (rst) begin
      flush_cnt_q <= '0;
    end else if (flush && ((state != ST_EMPTY) || in_valid) && !(&flush_cnt_q)) begin
      flush_cnt_q <= flush_cnt_q + CNT_WIDTH'(1);
    end
  end

  assign out_valid   = out_valid_q;
  assign out_ctrl    = head_ctrl;
  assign out_data    = head_data;
  assign occupancy   = state;
  assign flush_count = flush_cnt_q;

endmodule
